// File: rtl/cdc_toggle_rx.sv
// cdc_toggle_rx
// Receives bytes from an asynchronous sender over a two-phase (toggle)
// req/ack handshake. Synchronises req into the clk domain, captures the
// byte into a small FIFO and presents it downstream on valid/ready.
// Back-pressure is applied by withholding ack; data is never dropped.
//
// Ports:
//   clk         system clock, all state updates on its rising edge
//   rst_n       asynchronous active-low reset
//   async_data  sender byte, held stable from req toggle to ack toggle
//   async_req   sender request, one toggle per byte offered (asynchronous)
//   ack         registered acknowledge, toggles once per accepted byte
//   out_data    FIFO head byte, valid while out_valid=1
//   out_valid   FIFO not empty
//   out_ready   downstream accepts head when out_valid && out_ready
//   level       FIFO occupancy, 0..DEPTH
//   xfer_count  bytes accepted from the sender, wraps modulo 2^CNT_W
module cdc_toggle_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               async_data,
  input  logic                     async_req,
  output logic                     ack,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         xfer_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   req_s;
  logic                   req_prev_r;
  logic                   ack_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [PW-1:0]          wr_ptr_r;
  logic [PW-1:0]          rd_ptr_r;
  logic [PW-1:0]          level_r;
  logic [7:0]             mem_r [DEPTH];

  logic                   pending_s;
  logic                   pop_s;
  logic                   full_s;
  logic                   accept_s;

  // Only the last synchroniser flop is ever used by downstream logic.
  assign req_s = sync_r[SYNC_STAGES-1];

  assign out_valid  = (level_r != {PW{1'b0}});
  assign out_data   = mem_r[rd_ptr_r[AW-1:0]];
  assign ack        = ack_r;
  assign level      = level_r;
  assign xfer_count = cnt_r;

  // Handshake detection and accept decision; a full FIFO being popped this
  // cycle frees a slot, so the pending byte can still be taken.
  always_comb begin
    pending_s = (req_s != req_prev_r);
    pop_s     = out_valid && out_ready;
    full_s    = (level_r == PW'(DEPTH));
    accept_s  = pending_s && (!full_s || pop_s);
  end

  // Request synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], async_req};
    end
  end

  // Handshake state: remembered req phase, ack phase and transfer counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_prev_r <= 1'b0;
      ack_r      <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      req_prev_r <= req_s;
      ack_r      <= ~ack_r;
      cnt_r      <= cnt_r + CNT_W'(1);
    end else begin
      req_prev_r <= req_prev_r;
      ack_r      <= ack_r;
      cnt_r      <= cnt_r;
    end
  end

  // FIFO pointers and occupancy; pointers carry one extra wrap bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= {PW{1'b0}};
    end else begin
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({accept_s, pop_s})
        2'b10:   level_r <= level_r + PW'(1);
        2'b01:   level_r <= level_r - PW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // FIFO storage. async_data is sampled unsynchronised: the sender holds it
  // stable, and req_s only moves SYNC_STAGES edges after the data settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (accept_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= async_data;
    end
  end

endmodule

// File: tb/tb_cdc_toggle_rx.sv
module tb_cdc_toggle_rx;
  timeunit 1ns;
  timeprecision 1ps;

  logic       clk;
  logic       rst_n;
  logic [7:0] async_data;
  logic       async_req;
  logic       ack;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] level;
  logic [7:0] xfer_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_cnt;

  cdc_toggle_rx #(.SYNC_STAGES(2), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .async_data(async_data), .async_req(async_req),
    .ack(ack), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .xfer_count(xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Output monitor: pops the scoreboard on each transfer and checks that a
  // stalled head neither disappears nor changes.
  initial begin
    logic       prev_valid;
    logic       prev_ready;
    logic [7:0] prev_data;
    logic [7:0] exp_b;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (prev_valid && !prev_ready) begin
          total_cnt++;
          if (out_valid !== 1'b1 || out_data !== prev_data)
            $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h",
                     out_valid, out_data, prev_data);
          else pass_cnt++;
        end
        if (out_valid && out_ready) begin
          total_cnt++;
          if (exp_q.size() == 0) begin
            $display("FAIL sb_extra: got data=%h expected no output", out_data);
          end else begin
            exp_b = exp_q.pop_front();
            if (out_data !== exp_b)
              $display("FAIL sb_data: got %h expected %h", out_data, exp_b);
            else pass_cnt++;
          end
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_data  = out_data;
      end
    end
  end

  task automatic do_reset();
    rst_n      = 1'b0;
    async_req  = 1'b0;
    async_data = 8'h00;
    out_ready  = 1'b0;
    exp_q.delete();
    exp_cnt = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Sender: present data and toggle req; the byte joins the scoreboard.
  task automatic offer(input logic [7:0] d);
    async_data = d;
    async_req  = ~async_req;
    exp_q.push_back(d);
  endtask

  // Wait (bounded) for ack to match req; returns at posedge+1.
  task automatic wait_ack(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (ack == async_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (level == 3'd0) break;
    end
    out_ready = 1'b0;
    total_cnt++;
    if (level !== 3'd0 || exp_q.size() != 0)
      $display("FAIL drain: got level=%0d pending=%0d expected 0 and 0", level, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if ({ack, out_valid, out_data, level, xfer_count} !== 21'd0)
      $display("FAIL reset: got ack=%b v=%b d=%h lvl=%0d cnt=%h expected all 0",
               ack, out_valid, out_data, level, xfer_count);
    else pass_cnt++;
  endtask

  task automatic test_single();
    offer(8'h5A);
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (ack !== 1'b0) $display("FAIL early_ack: got %b expected 0", ack);
    else pass_cnt++;
    @(posedge clk);
    #1;
    exp_cnt++;
    total_cnt++;
    if (ack !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h5A ||
        level !== 3'd1 || xfer_count !== exp_cnt)
      $display("FAIL single: got ack=%b v=%b d=%h lvl=%0d cnt=%h expected 1 1 5a 1 %h",
               ack, out_valid, out_data, level, xfer_count, exp_cnt);
    else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || level !== 3'd0)
      $display("FAIL single_pop: got v=%b lvl=%0d expected 0 0", out_valid, level);
    else pass_cnt++;
  endtask

  task automatic test_fill_backpressure();
    bit ok;
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      offer(8'(i));
      wait_ack(20, ok);
      if (ok) exp_cnt++;
      total_cnt++;
      if (!ok) $display("FAIL fill_ack: got no ack expected ack for byte %0d", i);
      else pass_cnt++;
    end
    total_cnt++;
    if (level !== 3'd4) $display("FAIL fill_level: got %0d expected 4", level);
    else pass_cnt++;
    offer(8'h05);
    wait_ack(10, ok);
    total_cnt++;
    if (ok || level !== 3'd4 || xfer_count !== exp_cnt)
      $display("FAIL withheld: got ack_match=%b lvl=%0d cnt=%h expected 0 4 %h",
               ok, level, xfer_count, exp_cnt);
    else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    exp_cnt++;
    total_cnt++;
    if (ack !== async_req || level !== 3'd4 || xfer_count !== exp_cnt)
      $display("FAIL full_pop_accept: got ack=%b lvl=%0d cnt=%h expected %b 4 %h",
               ack, level, xfer_count, async_req, exp_cnt);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_concurrent();
    bit ok;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      offer(8'hA0 + 8'(i));
      wait_ack(20, ok);
      if (ok) exp_cnt++;
      total_cnt++;
      if (!ok) $display("FAIL conc_setup: got no ack expected ack");
      else pass_cnt++;
    end
    // Accept lands on the third edge after the offer; pop on that edge too.
    offer(8'hA2);
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    exp_cnt++;
    total_cnt++;
    if (level !== 3'd2 || ack !== async_req || xfer_count !== exp_cnt)
      $display("FAIL concurrent: got lvl=%0d ack=%b cnt=%h expected 2 %b %h",
               level, ack, xfer_count, async_req, exp_cnt);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_counter_wrap();
    bit ok;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      offer(8'(i * 7 + 3));
      wait_ack(20, ok);
      total_cnt++;
      if (!ok || xfer_count !== 8'(i + 1) || ack !== 1'((i + 1) % 2))
        $display("FAIL wrap_step: got ok=%b cnt=%h ack=%b expected 1 %h %b",
                 ok, xfer_count, ack, 8'(i + 1), 1'((i + 1) % 2));
      else pass_cnt++;
    end
    exp_cnt = 8'h00;
    total_cnt++;
    if (xfer_count !== 8'h00 || ack !== 1'b0)
      $display("FAIL wrap_final: got cnt=%h ack=%b expected 00 0", xfer_count, ack);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_jitter();
    bit ok;
    bit run;
    int fails;
    run = 1'b1;
    fails = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          real dly;
          dly = $urandom_range(1, 8990) / 1000.0;
          #(dly);
          offer(8'($urandom_range(0, 255)));
          wait_ack(40, ok);
          if (ok) exp_cnt++;
          else fails++;
        end
        run = 1'b0;
      end
      begin
        while (run) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    total_cnt++;
    if (fails != 0 || xfer_count !== exp_cnt)
      $display("FAIL jitter: got timeouts=%0d cnt=%h expected 0 %h", fails, xfer_count, exp_cnt);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      offer(8'h10 + 8'(i));
      wait_ack(20, ok);
      if (ok) exp_cnt++;
    end
    total_cnt++;
    if (level !== 3'd3) $display("FAIL mid_setup: got lvl=%0d expected 3", level);
    else pass_cnt++;
    offer(8'h13);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    async_req = 1'b0;
    exp_q.delete();
    exp_cnt = 8'h00;
    #1;
    total_cnt++;
    if ({ack, out_valid, out_data, level, xfer_count} !== 21'd0)
      $display("FAIL mid_reset: got ack=%b v=%b d=%h lvl=%0d cnt=%h expected all 0",
               ack, out_valid, out_data, level, xfer_count);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    offer(8'hC3);
    wait_ack(20, ok);
    if (ok) exp_cnt++;
    total_cnt++;
    if (!ok || xfer_count !== 8'h01 || out_data !== 8'hC3 || level !== 3'd1)
      $display("FAIL post_reset: got ok=%b cnt=%h d=%h lvl=%0d expected 1 01 c3 1",
               ok, xfer_count, out_data, level);
    else pass_cnt++;
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    async_req = 1'b0;
    async_data = 8'h00;
    out_ready = 1'b0;
    exp_cnt = 8'h00;
    test_reset();
    test_single();
    test_fill_backpressure();
    test_concurrent();
    test_counter_wrap();
    test_jitter();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cdc_toggle_rx.md
Name: cdc_toggle_rx

Overview:
- Receives bytes from an asynchronous external sender over pins using a two-phase (toggle) req/ack handshake.
- Synchronises req into the clk domain, captures the byte, and buffers it in a small FIFO.
- Presents buffered bytes downstream on a valid/ready interface; this is the stage that feeds the chip's byte-consuming datapath.
- Applies back-pressure by withholding ack; it never drops data.

Parameters:
- SYNC_STAGES, 2, number of flops in the req synchroniser chain (legal >= 2).
- DEPTH, 4, FIFO entries (power of 2, legal >= 2).
- CNT_W, 8, width of the accepted-transfer counter.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- async_data  input  8  sender data; held stable by the sender from its req toggle until the matching ack toggle.
- async_req  input  1  sender request; one toggle equals one byte offered; asynchronous to clk.
- ack  output  1  registered acknowledge; toggles once per accepted byte.
- out_data  output  8  FIFO head byte; valid only while out_valid=1.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  downstream accepts the head byte when out_valid and out_ready are both 1 at a rising edge.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- xfer_count  output  CNT_W  count of bytes accepted from the sender; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, released synchronously by the environment):
  - Sync chain, req_prev, ack, FIFO pointers, level and xfer_count are all 0.
  - out_valid=0; out_data=0 (storage is cleared).
- Synchroniser:
  - async_req enters a SYNC_STAGES flop chain; req_s is the last flop.
  - No logic may use async_req or any earlier chain flop.
- Detection: pending = (req_s != req_prev), combinational.
- Accept condition: accept = pending && (!full || pop).
  - pop = out_valid && out_ready.
  - A full FIFO that is popped in the same cycle still accepts.
- On accept, at the edge:
  - Write async_data into the FIFO tail.
  - req_prev <= req_s.
  - ack <= ~ack.
  - xfer_count += 1, wrapping modulo 2^CNT_W.
- async_data is sampled directly, unsynchronised. This is safe because the sender holds it stable, and req_s can only change >= SYNC_STAGES edges after the data settled.
- Latency: if async_req toggles between edges, the first edge that samples it is edge 1.
  - req_s changes after edge SYNC_STAGES.
  - Capture and ack toggle happen at edge SYNC_STAGES+1 (3 edges for the default).
  - out_valid rises after that same edge, when the FIFO was empty.
- Back-pressure: when full and not popping, pending stays high, and ack, req_prev and the counter hold. The accept completes at the first edge with pop=1.
- FIFO:
  - Read and write pointers are $clog2(DEPTH)+1 bits wide.
  - full = (level==DEPTH); empty = (level==0).
  - out_data is the head entry (storage read, no extra register stage).
  - Simultaneous push and pop leaves level unchanged; both pointers advance.
  - A pop when empty is ignored.
  - Pointers wrap naturally.
- At most one byte is accepted per handshake. A second req toggle before ack is a protocol violation and its result is undefined (the bench must not generate it).
- Reset mid-operation:
  - FIFO contents, pending toggle and counter are lost.
  - The sender must also return req to 0 and expect ack=0. Otherwise a req=1 after reset is seen as a new toggle and captured.
- out_valid and out_data must not change while out_valid=1 && out_ready=0, except through the reset path.

Test Plan:
- Single transfer: reset, then async_data=0x5A with async_req 0->1 → ack 0->1 exactly 3 edges after the first sampling edge; out_valid=1, out_data=0x5A, level=1, xfer_count=1. Then out_ready=1 for one edge → out_valid=0, level=0.
- Fill and back-pressure: out_ready=0; send 0x01..0x05 with proper handshake → the first 4 are acked, level=4, and the 5th ack is withheld. Pulse out_ready for one edge → the 5th is accepted that same edge (level stays 4). Drain reads 0x01..0x05 in order.
- Concurrent push/pop: level=2 and out_ready=1 held while a new byte is accepted → level stays 2; order preserved.
- Counter wrap: 256 back-to-back transfers with out_ready=1 → xfer_count returns to 0x00; every byte emerges in order; ack parity equals the transfer count mod 2.
- Async jitter: async_req toggles at random sub-cycle offsets, with data changed only after ack → no lost or duplicated bytes over 1000 transfers; scoreboard matches.
- Reset mid-stream: assert rst_n=0 with level=3 and a req pending; the sender also resets req to 0 → all outputs 0 immediately (asynchronously). After release, a fresh transfer of 0xC3 completes normally with xfer_count=1.
